// File: rtl/alu_pkg.sv
// Shared types and constants for the sign-magnitude ALU slice.
//   SM_W / MAG_W  : operand width (sign + magnitude) and magnitude width
//   OP_ADD/OP_SUB : requester opcode encoding
//   sm_operand_t  : {sign, mag[3:0]} operand
//   sm_result_t   : {sign, mag[4:0]} result, one extra bit for carry-out
//   res_state_t   : occupancy of the single result register
package alu_pkg;
  localparam int SM_W  = 5;
  localparam int MAG_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sm_operand_t;

  typedef struct packed {
    logic           sign;
    logic [MAG_W:0] mag;
  } sm_result_t;

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_t;
endpackage

// File: rtl/sm_add_core.sv
// Combinational sign-magnitude adder/subtractor.
//   i_x, i_y : sign-magnitude operands
//   i_op     : OP_ADD computes X+Y, OP_SUB computes X-Y
//   o_res    : sign-magnitude result; a zero magnitude always reports sign 0
import alu_pkg::*;

module sm_add_core (
  input  sm_operand_t i_x,
  input  sm_operand_t i_y,
  input  logic        i_op,
  output sm_result_t  o_res
);
  logic w_ys;

  // Subtraction is addition with Y's sign flipped.
  assign w_ys = i_y.sign ^ i_op;

  always_comb begin
    o_res = '0;
    if (i_x.sign == w_ys) begin
      o_res.mag  = {1'b0, i_x.mag} + {1'b0, i_y.mag};
      o_res.sign = i_x.sign;
    end else if (i_x.mag > i_y.mag) begin
      o_res.mag  = {1'b0, i_x.mag - i_y.mag};
      o_res.sign = i_x.sign;
    end else begin
      o_res.mag  = {1'b0, i_y.mag - i_x.mag};
      o_res.sign = w_ys;
    end
    // No negative zero: covers -0 operands and exact cancellation.
    if (o_res.mag == '0) o_res.sign = 1'b0;
  end
endmodule

// File: rtl/sm_adder_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude adder among NUM_REQ
// requesters, with a single registered, tagged result port.
//   clk, reset          : clock, async active-high reset
//   reqValid/reqReady   : per-requester handshake (reqReady one-hot or zero)
//   reqOp, reqX, reqY   : per-requester opcode and 5-bit operands (slice i = [5i+4:5i])
//   resValid/resReady   : result handshake
//   resSign/Mag/Zero/Tag: registered result and originating requester index
// Optional (macro ALU_ARB_STATS_EN): statsClr input and grantCount output,
// one saturating 16-bit transfer counter per requester.
import alu_pkg::*;

module sm_adder_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      reqValid,
  output logic [NUM_REQ-1:0]      reqReady,
  input  logic [NUM_REQ-1:0]      reqOp,
  input  logic [SM_W*NUM_REQ-1:0] reqX,
  input  logic [SM_W*NUM_REQ-1:0] reqY,
  output logic                    resValid,
  input  logic                    resReady,
  output logic                    resSign,
  output logic [MAG_W:0]          resMag,
  output logic                    resZero,
  output logic [TAG_W-1:0]        resTag
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic                    statsClr,
  output logic [16*NUM_REQ-1:0]   grantCount
`endif
);
  res_state_t       r_state, w_state_nxt;
  logic [TAG_W-1:0] r_ptr;
  logic             r_sign, r_zero;
  logic [MAG_W:0]   r_mag;
  logic [TAG_W-1:0] r_tag;

  logic             w_can, w_gnt_vld, w_xfer, w_op;
  logic [TAG_W-1:0] w_gnt;
  sm_operand_t      w_x, w_y;
  sm_result_t       w_res;
  int               w_dist, w_best;

  // Requests are frozen while reset is high so nothing slips in mid-reset.
  assign w_can  = ((r_state == RES_EMPTY) || resReady) && !reset;
  assign w_xfer = w_can && w_gnt_vld;

  // Winner = valid requester with the smallest distance past the pointer.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_x       = '0;
    w_y       = '0;
    w_op      = OP_ADD;
    w_dist    = 0;
    w_best    = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j + NUM_REQ - 1 - int'(r_ptr)) % NUM_REQ;
      if (reqValid[j] && (w_dist < w_best)) begin
        w_best    = w_dist;
        w_gnt_vld = 1'b1;
        w_gnt     = TAG_W'(j);
        w_x       = reqX[j*SM_W +: SM_W];
        w_y       = reqY[j*SM_W +: SM_W];
        w_op      = reqOp[j];
      end
    end
  end

  always_comb begin
    reqReady = '0;
    for (int j = 0; j < NUM_REQ; j++)
      reqReady[j] = w_xfer && (w_gnt == TAG_W'(j));
  end

  sm_add_core u_core (
    .i_x   (w_x),
    .i_y   (w_y),
    .i_op  (w_op),
    .o_res (w_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RES_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RES_EMPTY: if (w_xfer) w_state_nxt = RES_FULL;
      RES_FULL:  if (resReady && !w_xfer) w_state_nxt = RES_EMPTY;
      default:   w_state_nxt = RES_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr  <= TAG_W'(NUM_REQ - 1);
      r_sign <= 1'b0;
      r_mag  <= '0;
      r_zero <= 1'b1;
      r_tag  <= '0;
    end else if (w_xfer) begin
      r_ptr  <= w_gnt;
      r_sign <= w_res.sign;
      r_mag  <= w_res.mag;
      r_zero <= (w_res.mag == '0);
      r_tag  <= w_gnt;
    end
  end

  assign resValid = (r_state == RES_FULL);
  assign resSign  = r_sign;
  assign resMag   = r_mag;
  assign resZero  = r_zero;
  assign resTag   = r_tag;

`ifdef ALU_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [15:0] r_cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_cnt <= '0;
      else if (statsClr) r_cnt <= '0;
      else if (w_xfer && (w_gnt == TAG_W'(i)) && (r_cnt != 16'hFFFF))
        r_cnt <= r_cnt + 16'd1;
    end
    assign grantCount[16*i +: 16] = r_cnt;
  end
`endif
endmodule

// File: tb/tb_sm_adder_arbiter.sv
// Directed self-checking bench for sm_adder_arbiter (NUM_REQ=2, TAG_W=1).
// Covers reset state, add/sub sign cases, saturation-free max, negative-zero
// normalisation, round-robin alternation, backpressure and async reset.
// With ALU_ARB_STATS_EN defined it also checks the grant counters.
import alu_pkg::*;

module tb_sm_adder_arbiter;
  logic        clk;
  logic        reset;
  logic [1:0]  reqValid, reqReady, reqOp;
  logic [9:0]  reqX, reqY;
  logic        resValid, resReady, resSign, resZero;
  logic [4:0]  resMag;
  logic [0:0]  resTag;
`ifdef ALU_ARB_STATS_EN
  logic        statsClr;
  logic [31:0] grantCount;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  sm_adder_arbiter #(.NUM_REQ(2), .TAG_W(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .reqOp    (reqOp),
    .reqX     (reqX),
    .reqY     (reqY),
    .resValid (resValid),
    .resReady (resReady),
    .resSign  (resSign),
    .resMag   (resMag),
    .resZero  (resZero),
    .resTag   (resTag)
`ifdef ALU_ARB_STATS_EN
    ,
    .statsClr   (statsClr),
    .grantCount (grantCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-requester operation: present, check grant, clock, check result.
  task automatic run_op(input int r, input logic op, input logic [4:0] x,
                        input logic [4:0] y, input logic es, input logic [4:0] em,
                        input string tag);
    if (r == 0) begin
      reqValid = 2'b01; reqOp[0] = op; reqX[4:0] = x; reqY[4:0] = y;
    end else begin
      reqValid = 2'b10; reqOp[1] = op; reqX[9:5] = x; reqY[9:5] = y;
    end
    #1;
    chk({tag, "_rdy"}, 32'(reqReady), (r == 0) ? 32'h1 : 32'h2);
    tick();
    reqValid = 2'b00;
    chk({tag, "_vld"},  32'(resValid), 32'h1);
    chk({tag, "_sign"}, 32'(resSign),  32'(es));
    chk({tag, "_mag"},  32'(resMag),   32'(em));
    chk({tag, "_zero"}, 32'(resZero),  (em == 5'd0) ? 32'h1 : 32'h0);
    chk({tag, "_tag"},  32'(resTag),   32'(r));
  endtask

  initial begin
    reset    = 1'b1;
    reqValid = 2'b11;
    reqOp    = '0;
    reqX     = '0;
    reqY     = '0;
    resReady = 1'b1;
`ifdef ALU_ARB_STATS_EN
    statsClr = 1'b0;
`endif
    tick(); tick();
    chk("rst_vld",  32'(resValid), 32'h0);
    chk("rst_sign", 32'(resSign),  32'h0);
    chk("rst_mag",  32'(resMag),   32'h0);
    chk("rst_zero", 32'(resZero),  32'h1);
    chk("rst_tag",  32'(resTag),   32'h0);
    chk("rst_rdy",  32'(reqReady), 32'h0);
    reqValid = 2'b00;
    reset    = 1'b0;
    tick();

    run_op(0, OP_ADD, 5'b00101, 5'b00111, 1'b0, 5'd12, "p5_add_p7");
    run_op(1, OP_SUB, 5'b10011, 5'b01001, 1'b1, 5'd12, "m3_sub_p9");
    run_op(1, OP_ADD, 5'b01111, 5'b01111, 1'b0, 5'd30, "max_add");
    run_op(0, OP_SUB, 5'b00110, 5'b00110, 1'b0, 5'd0,  "cancel");
    run_op(0, OP_ADD, 5'b10000, 5'b10000, 1'b0, 5'd0,  "negzero");
    run_op(0, OP_SUB, 5'b01001, 5'b00011, 1'b0, 5'd6,  "x_gt_y");
    run_op(0, OP_ADD, 5'b10100, 5'b00100, 1'b0, 5'd0,  "eqmag");
    run_op(1, OP_SUB, 5'b00010, 5'b00111, 1'b1, 5'd5,  "x_lt_y");

    // Drain with no new transfer: valid drops, fields hold.
    tick();
    chk("drain_vld",  32'(resValid), 32'h0);
    chk("drain_mag",  32'(resMag),   32'd5);
    chk("drain_sign", 32'(resSign),  32'h1);
    chk("drain_tag",  32'(resTag),   32'h1);

    // Both requesters always valid: 0 gives 2, 1 gives 4; grants alternate.
    reqOp    = 2'b00;
    reqX     = {5'b00011, 5'b00001};
    reqY     = {5'b00001, 5'b00001};
    reqValid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_rdy", 32'(reqReady), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      chk("rr_vld", 32'(resValid), 32'h1);
      chk("rr_tag", 32'(resTag),   32'(i % 2));
      chk("rr_mag", 32'(resMag),   (i % 2 == 0) ? 32'd2 : 32'd4);
    end

    // Backpressure: result tag1/mag4 must hold, no grants.
    resReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy", 32'(reqReady), 32'h0);
      tick();
      chk("bp_vld", 32'(resValid), 32'h1);
      chk("bp_tag", 32'(resTag),   32'h1);
      chk("bp_mag", 32'(resMag),   32'd4);
    end
    resReady = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(reqReady), 32'h1);
    tick();
    chk("bp_rel_vld", 32'(resValid), 32'h1);
    chk("bp_rel_tag", 32'(resTag),   32'h0);
    chk("bp_rel_mag", 32'(resMag),   32'd2);

    // Async reset between edges with a result held.
    #2;
    reset = 1'b1;
    #1;
    chk("arst_vld",  32'(resValid), 32'h0);
    chk("arst_zero", 32'(resZero),  32'h1);
    chk("arst_mag",  32'(resMag),   32'h0);
    chk("arst_rdy",  32'(reqReady), 32'h0);
`ifdef ALU_ARB_STATS_EN
    chk("arst_cnt",  grantCount,    32'h0);
`endif
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_rdy", 32'(reqReady), 32'h1);
    tick();
    chk("post_rst_tag", 32'(resTag), 32'h0);
    chk("post_rst_mag", 32'(resMag), 32'd2);
`ifdef ALU_ARB_STATS_EN
    chk("cnt_one", grantCount, {16'd0, 16'd1});
    reqValid = 2'b10;
    statsClr = 1'b1;
    tick();
    chk("cnt_clr_prio", grantCount, 32'h0);
    chk("cnt_clr_tag",  32'(resTag), 32'h1);
    statsClr = 1'b0;
    tick();
    chk("cnt_inc", grantCount, {16'd1, 16'd0});
`endif
    reqValid = 2'b00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
